// File: rtl/bfu_pipe.sv
// Three-stage pipelined NTT butterfly unit (GS / CT / pointwise multiply / bypass)
// with valid/ready handshaking on both sides and a sideband tag per transaction.
module bfu_pipe #(
    parameter int WIDTH = 24,
    parameter int Q     = 8380417,
    parameter int TAG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] w_i,
    input  logic [1:0]       mode_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] even_o,
    output logic [WIDTH-1:0] odd_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        MODE_GS  = 2'b00,
        MODE_CT  = 2'b01,
        MODE_PWM = 2'b10,
        MODE_BYP = 2'b11
    } mode_e;

    localparam logic [WIDTH:0]     QE = (WIDTH+1)'(Q);
    localparam logic [2*WIDTH-1:0] QL = (2*WIDTH)'(Q);

    function automatic logic [WIDTH-1:0] modAdd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QE) begin
            s = s - QE;
        end
        return WIDTH'(s);
    endfunction

    // Wraps in WIDTH+1 bits when x < y; adding Q brings it back into [0, Q-1].
    function automatic logic [WIDTH-1:0] modSub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (x < y) begin
            d = d + QE;
        end
        return WIDTH'(d);
    endfunction

    function automatic logic [WIDTH-1:0] modMul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [2*WIDTH-1:0] p;
        p = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
        return WIDTH'(p % QL);
    endfunction

    logic             r1_valid, r2_valid, r3_valid;
    logic [WIDTH-1:0] r1_x, r1_y, r1_w;
    logic [WIDTH-1:0] r2_p, r2_y;
    logic [WIDTH-1:0] r3_even, r3_odd;
    mode_e            r1_mode, r2_mode;
    logic [TAG_W-1:0] r1_tag, r2_tag, r3_tag;

    logic             w_adv1, w_adv2, w_adv3;
    logic [WIDTH-1:0] w_s1X, w_s1Y;
    logic [WIDTH-1:0] w_s2P;
    logic [WIDTH-1:0] w_s3Even, w_s3Odd;

    assign w_adv3 = !r3_valid || out_ready_i;
    assign w_adv2 = !r2_valid || w_adv3;
    assign w_adv1 = !r1_valid || w_adv2;

    assign in_ready_o  = w_adv1;
    assign out_valid_o = r3_valid;
    assign even_o      = r3_even;
    assign odd_o       = r3_odd;
    assign tag_o       = r3_tag;
    assign busy_o      = r1_valid || r2_valid || r3_valid;

    // x is the operand that stage 2 multiplies by w; y rides alongside unchanged.
    always_comb begin
        w_s1X = a_i;
        w_s1Y = b_i;
        case (mode_e'(mode_i))
            MODE_GS: begin
                w_s1X = modSub(a_i, b_i);
                w_s1Y = modAdd(a_i, b_i);
            end
            MODE_CT: begin
                w_s1X = b_i;
                w_s1Y = a_i;
            end
            default: begin
                w_s1X = a_i;
                w_s1Y = b_i;
            end
        endcase
    end

    assign w_s2P = (r1_mode == MODE_BYP) ? r1_x : modMul(r1_x, r1_w);

    always_comb begin
        w_s3Even = r2_p;
        w_s3Odd  = r2_y;
        case (r2_mode)
            MODE_GS: begin
                w_s3Even = r2_y;
                w_s3Odd  = r2_p;
            end
            MODE_CT: begin
                w_s3Even = modAdd(r2_y, r2_p);
                w_s3Odd  = modSub(r2_y, r2_p);
            end
            default: begin
                w_s3Even = r2_p;
                w_s3Odd  = r2_y;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r1_valid <= 1'b0;
            r1_x     <= '0;
            r1_y     <= '0;
            r1_w     <= '0;
            r1_mode  <= MODE_GS;
            r1_tag   <= '0;
        end else if (w_adv1) begin
            r1_valid <= in_valid_i;
            if (in_valid_i) begin
                r1_x    <= w_s1X;
                r1_y    <= w_s1Y;
                r1_w    <= w_i;
                r1_mode <= mode_e'(mode_i);
                r1_tag  <= tag_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r2_valid <= 1'b0;
            r2_p     <= '0;
            r2_y     <= '0;
            r2_mode  <= MODE_GS;
            r2_tag   <= '0;
        end else if (w_adv2) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_p    <= w_s2P;
                r2_y    <= r1_y;
                r2_mode <= r1_mode;
                r2_tag  <= r1_tag;
            end
        end
    end

    // Output register only loads on advance, so a stalled result stays frozen.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r3_valid <= 1'b0;
            r3_even  <= '0;
            r3_odd   <= '0;
            r3_tag   <= '0;
        end else if (w_adv3) begin
            r3_valid <= r2_valid;
            if (r2_valid) begin
                r3_even <= w_s3Even;
                r3_odd  <= w_s3Odd;
                r3_tag  <= r2_tag;
            end
        end
    end

endmodule

// File: tb/tb_bfu_pipe.sv
// Self-checking bench for bfu_pipe: directed butterfly cases, backpressure,
// mixed-mode streaming, mid-flight reset and a randomized handshake run.
module tb_bfu_pipe;

    localparam int WIDTH = 24;
    localparam int Q     = 8380417;
    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             inValid = 1'b0;
    logic             inReady;
    logic [WIDTH-1:0] a = '0, b = '0, w = '0;
    logic [1:0]       mode = 2'b00;
    logic [TAG_W-1:0] tag = '0;
    logic             outValid;
    logic             outReady = 1'b1;
    logic [WIDTH-1:0] even, odd;
    logic [TAG_W-1:0] tagOut;
    logic             busy;

    bfu_pipe #(.WIDTH(WIDTH), .Q(Q), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(inValid), .in_ready_o(inReady),
        .a_i(a), .b_i(b), .w_i(w), .mode_i(mode), .tag_i(tag),
        .out_valid_o(outValid), .out_ready_i(outReady),
        .even_o(even), .odd_o(odd), .tag_o(tagOut), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] even;
        logic [WIDTH-1:0] odd;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             expQ[$];
    int               total = 0;
    int               bad = 0;
    logic [WIDTH-1:0] curEven, curOdd;
    int               cycleCount = 0;
    int               fireCount = 0;
    int               firstFireCycle = -1;
    int               lastFireCycle = -1;
    logic             sawOutValid = 1'b0;
    logic             acceptedLast = 1'b0;

    // Butterfly results straight from the arithmetic definitions, using 64-bit integers.
    function automatic void refModel(input logic [1:0] m, input longint ai, input longint bi,
                                     input longint wi, output logic [WIDTH-1:0] e,
                                     output logic [WIDTH-1:0] o);
        longint t, ee, oo;
        case (m)
            2'b00: begin
                ee = (ai + bi) % Q;
                oo = (wi * ((ai - bi + Q) % Q)) % Q;
            end
            2'b01: begin
                t  = (wi * bi) % Q;
                ee = (ai + t) % Q;
                oo = (ai - t + Q) % Q;
            end
            2'b10: begin
                ee = (ai * wi) % Q;
                oo = bi;
            end
            default: begin
                ee = ai;
                oo = bi;
            end
        endcase
        e = WIDTH'(ee);
        o = WIDTH'(oo);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [WIDTH-1:0] ai,
                                 input logic [WIDTH-1:0] bi, input logic [WIDTH-1:0] wi,
                                 input logic [TAG_W-1:0] t);
        inValid = 1'b1;
        mode    = m;
        a       = ai;
        b       = bi;
        w       = wi;
        tag     = t;
        refModel(m, longint'(ai), longint'(bi), longint'(wi), curEven, curOdd);
    endtask

    task automatic applyDirected(input logic [1:0] m, input logic [WIDTH-1:0] ai,
                                 input logic [WIDTH-1:0] bi, input logic [WIDTH-1:0] wi,
                                 input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] e,
                                 input logic [WIDTH-1:0] o);
        inValid = 1'b1;
        mode    = m;
        a       = ai;
        b       = bi;
        w       = wi;
        tag     = t;
        curEven = e;
        curOdd  = o;
    endtask

    task automatic applyRandom(input logic [TAG_W-1:0] t);
        applyStimulus(2'($urandom_range(0, 3)), WIDTH'($urandom_range(0, Q - 1)),
                      WIDTH'($urandom_range(0, Q - 1)), WIDTH'($urandom_range(0, Q - 1)), t);
    endtask

    task automatic idle();
        inValid = 1'b0;
    endtask

    // One clock: sample at the falling edge, score any delivered result, record any acceptance.
    task automatic cycle();
        exp_t x;
        @(negedge clk);
        sawOutValid  = outValid;
        acceptedLast = inValid && inReady;
        if (outValid && outReady) begin
            fireCount++;
            if (firstFireCycle < 0) firstFireCycle = cycleCount;
            lastFireCycle = cycleCount;
            checkOutput("result_was_expected", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                x = expQ.pop_front();
                checkOutput("even", 32'(even), 32'(x.even));
                checkOutput("odd", 32'(odd), 32'(x.odd));
                checkOutput("tag", 32'(tagOut), 32'(x.tag));
            end
        end
        if (inValid && inReady) begin
            x.even = curEven;
            x.odd  = curOdd;
            x.tag  = tag;
            expQ.push_back(x);
        end
        cycleCount++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        outReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (expQ.size() == 0 && !busy) break;
            cycle();
        end
        checkOutput("drain_complete", 32'(expQ.size() == 0 && !busy), 32'd1);
    endtask

    task automatic measureLatency(input string name);
        int lat;
        lat = -1;
        idle();
        for (int i = 1; i <= 8; i++) begin
            cycle();
            if (sawOutValid) begin
                lat = i;
                break;
            end
        end
        checkOutput(name, 32'(lat), 32'd3);
    endtask

    initial begin
        int accepts;
        int nextTag;
        logic [WIDTH-1:0] e0, o0;
        logic [TAG_W-1:0] t0;

        // Reset state
        #12;
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_even", 32'(even), 32'd0);
        checkOutput("rst_odd", 32'(odd), 32'd0);
        checkOutput("rst_tag", 32'(tagOut), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_reset", 32'(inReady), 32'd1);

        // CT latency with a known answer
        $display("[TB] CT latency");
        applyDirected(2'b01, 1, 2, 3, 8'h11, 7, 8380412);
        cycle();
        checkOutput("ct_accepted", 32'(acceptedLast), 32'd1);
        measureLatency("ct_latency");
        drain();

        // Directed GS / CT / PWM edge values, streamed back-to-back
        $display("[TB] directed boundary cases");
        applyDirected(2'b00, 5, 3, 4, 8'h21, 8, 8);
        cycle();
        applyDirected(2'b00, 3, 5, 1, 8'h22, 8, 8380415);
        cycle();
        applyDirected(2'b01, 8380416, 1, 1, 8'h23, 0, 8380415);
        cycle();
        applyDirected(2'b10, 8380416, 9, 8380416, 8'h24, 1, 9);
        cycle();
        drain();

        // Backpressure: three fill the pipe, then in_ready drops
        $display("[TB] backpressure");
        outReady  = 1'b0;
        nextTag   = 1;
        accepts   = 0;
        fireCount = 0;
        for (int i = 0; i < 5; i++) begin
            applyRandom(TAG_W'(nextTag));
            cycle();
            if (acceptedLast) begin
                accepts++;
                nextTag++;
            end
        end
        checkOutput("bp_accepted", 32'(accepts), 32'd3);
        checkOutput("bp_in_ready_low", 32'(inReady), 32'd0);
        idle();
        e0 = even;
        o0 = odd;
        t0 = tagOut;
        cycle();
        cycle();
        checkOutput("bp_stall_valid", 32'(outValid), 32'd1);
        checkOutput("bp_stall_even", 32'(even), 32'(e0));
        checkOutput("bp_stall_odd", 32'(odd), 32'(o0));
        checkOutput("bp_stall_tag", 32'(tagOut), 32'(t0));
        checkOutput("bp_head_tag", 32'(tagOut), 32'd1);
        outReady = 1'b1;
        for (int i = 0; i < 20 && nextTag <= 5; i++) begin
            applyRandom(TAG_W'(nextTag));
            cycle();
            if (acceptedLast) nextTag++;
        end
        drain();
        checkOutput("bp_result_count", 32'(fireCount), 32'd5);

        // Mixed modes on consecutive cycles
        $display("[TB] interleaved modes");
        fireCount      = 0;
        firstFireCycle = -1;
        outReady       = 1'b1;
        applyStimulus(2'b00, WIDTH'($urandom_range(0, Q - 1)), WIDTH'($urandom_range(0, Q - 1)),
                      WIDTH'($urandom_range(0, Q - 1)), 8'h41);
        cycle();
        applyStimulus(2'b01, WIDTH'($urandom_range(0, Q - 1)), WIDTH'($urandom_range(0, Q - 1)),
                      WIDTH'($urandom_range(0, Q - 1)), 8'h42);
        cycle();
        applyStimulus(2'b11, WIDTH'($urandom_range(0, Q - 1)), WIDTH'($urandom_range(0, Q - 1)),
                      WIDTH'($urandom_range(0, Q - 1)), 8'h43);
        cycle();
        applyStimulus(2'b10, WIDTH'($urandom_range(0, Q - 1)), WIDTH'($urandom_range(0, Q - 1)),
                      WIDTH'($urandom_range(0, Q - 1)), 8'h44);
        cycle();
        drain();
        checkOutput("mix_count", 32'(fireCount), 32'd4);
        checkOutput("mix_back_to_back", 32'(lastFireCycle - firstFireCycle), 32'd3);

        // Reset with two transactions in flight
        $display("[TB] mid-flight reset");
        outReady = 1'b0;
        applyRandom(8'h51);
        cycle();
        applyRandom(8'h52);
        cycle();
        idle();
        cycle();
        cycle();
        checkOutput("pre_rst_valid", 32'(outValid), 32'd1);
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(outValid), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        expQ.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        outReady  = 1'b1;
        fireCount = 0;
        for (int i = 0; i < 6; i++) cycle();
        checkOutput("no_stale_after_rst", 32'(fireCount), 32'd0);
        applyRandom(8'h53);
        cycle();
        checkOutput("post_rst_accepted", 32'(acceptedLast), 32'd1);
        measureLatency("post_rst_latency");
        drain();

        // Randomized traffic with random stalls on both sides
        $display("[TB] random traffic");
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) != 0) applyRandom(TAG_W'(i));
            else idle();
            outReady = ($urandom_range(0, 2) != 0);
            cycle();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bfu_pipe.md
BFU_PIPE -- requirements
Module: bfu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 24: coefficient/twiddle width.
REQ-002 SHALL have parameter Q, default 8380417: modulus, with 2 <= Q < 2^WIDTH.
REQ-003 SHALL have parameter TAG_W, default 8: sideband tag width.
REQ-004 SHALL have one clock; reset is asynchronous and active-high, with ports clk_i and rst_i.
REQ-005 SHALL have port clk_i  in  1  rising-edge clock.
REQ-006 SHALL have port rst_i  in  1  asynchronous active-high reset.
REQ-007 SHALL have port in_valid_i  in  1  input operand set valid.
REQ-008 SHALL have port in_ready_o  out  1  block can accept an input this cycle.
REQ-009 SHALL have ports a_i, b_i  in  WIDTH  operands in [0, Q-1].
REQ-010 SHALL have port w_i  in  WIDTH  twiddle/multiplier in [0, Q-1].
REQ-011 SHALL have port mode_i  in  2  operation: 00 GS, 01 CT, 10 PWM, 11 BYPASS.
REQ-012 SHALL have port tag_i  in  TAG_W  opaque sideband carried with the operands.
REQ-013 SHALL have port out_valid_o  out  1  result valid.
REQ-014 SHALL have port out_ready_i  in  1  downstream accepts the result.
REQ-015 SHALL have ports even_o, odd_o  out  WIDTH  results in [0, Q-1].
REQ-016 SHALL have port tag_o  out  TAG_W  tag of the presented result.
REQ-017 SHALL have port busy_o  out  1  any pipeline stage holds valid data.

Function
REQ-018 SHALL accept an input on any rising edge where in_valid_i and in_ready_o are both high.
REQ-019 SHALL deliver a result on any rising edge where out_valid_o and out_ready_i are both high.
REQ-020 SHALL implement 3 registered stages: S1 pre-add/sub, S2 modular multiply, S3 post-add/sub and output register.
REQ-021 SHALL present out_valid_o exactly 3 cycles after acceptance when there is no backpressure; with continuous valid and ready, throughput SHALL be 1 result per cycle.
REQ-022 SHALL advance stage k when that stage is empty or stage k+1 advances; stage 3 advances when it is empty or out_ready_i is high.
REQ-023 SHALL drive in_ready_o = !S1_valid || S1_advance, so bubbles collapse and up to 3 results are buffered under stall.
REQ-024 SHALL carry mode and tag with the data of each transaction, so that mixed modes in flight are each computed per their own mode.
REQ-025 CT (01) SHALL compute t = w*b mod Q, even = (a+t) mod Q, and odd = (a-t) mod Q.
REQ-026 GS (00) SHALL compute even = (a+b) mod Q and odd = w*((a-b) mod Q) mod Q.
REQ-027 PWM (10) SHALL compute even = a*w mod Q and odd = b.
REQ-028 BYPASS (11) SHALL compute even = a and odd = b.
REQ-029 SHALL use a full 2*WIDTH-bit product in the multiplier, fully reduced mod Q; adders SHALL use WIDTH+1-bit intermediates and a single conditional subtract/add of Q.
REQ-030 SHALL hold even_o, odd_o, tag_o and out_valid_o stable while out_valid_o && !out_ready_i.
REQ-031 SHALL permit out_ready_i to depend on nothing from this block; there SHALL be no combinational path from in_valid_i to out_valid_o.
REQ-032 SHALL drive busy_o as the OR of the three stage valid bits.
REQ-033 Behaviour for operands >= Q is unspecified, and the bench SHALL NOT drive them.

Reset
REQ-034 While rst_i is high, all stage valid bits SHALL be cleared immediately and out_valid_o=0, busy_o=0, and even_o=odd_o=tag_o=0.
REQ-035 in_ready_o SHALL be 1 from the first edge after reset release.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight transactions, and no result for them SHALL ever appear.

Verification
REQ-037 The bench SHALL cover CT with a=1, b=2, w=3, ready=1: even=7 and odd=8380412 exactly 3 cycles after acceptance.
REQ-038 The bench SHALL cover GS with a=5, b=3, w=4: even=8 and odd=8; GS with a=3, b=5, w=1: even=8 and odd=8380415.
REQ-039 The bench SHALL cover CT with a=8380416, b=1, w=1: even=0 and odd=8380415; PWM with a=8380416, w=8380416, b=9: even=1 and odd=9.
REQ-040 The bench SHALL cover backpressure: hold out_ready_i=0 and offer 5 back-to-back inputs tagged 1..5, so that exactly 3 are accepted and in_ready_o=0 after that; then raise out_ready_i, after which tags 1..5 appear in order with no loss or duplication and outputs are stable while stalled.
REQ-041 The bench SHALL cover an interleaved mode stream GS, CT, BYPASS, PWM on consecutive cycles: each result matches its own mode per REQ-025..REQ-028, with 1 result per cycle.
REQ-042 The bench SHALL cover rst_i pulsed with 2 transactions in flight: out_valid_o and busy_o drop asynchronously, no stale result appears afterward, and a new transaction completes after 3 cycles.
